acc_stream_rx: RTL
==================

# acc_stream_rx

Receive-side stream buffer between the SDRAM-read DMA engine and the accelerator datapath. The DMA pushes one word per cycle on a valid-only interface with no backpressure. This block absorbs those bursts in a first-word-fall-through FIFO and re-presents the words on a valid/ready stream with frame-boundary marking. It records overflow, counts dropped words, and exposes control and status to the CPU through a small Wishbone slave window.

## Interface
- DATA_WIDTH, 32, stream word width
- DEPTH, 8, FIFO entries; power of two, ≥2
- wb_clk_i  input  1  clock; all logic on the rising edge
- wb_rst_i  input  1  reset, asynchronous, active-high
- in_valid  input  1  DMA word strobe, driven by the DMA `acc_data_valid_i` output; no ready returned
- in_data  input  DATA_WIDTH  DMA word, driven by the DMA `acc_data_i` output
- out_valid  output  1  FIFO non-empty
- out_data  output  DATA_WIDTH  head word; 0 when out_valid=0
- out_last  output  1  head word is the final word of the current frame
- out_ready  input  1  accelerator accepts the head word
- wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone strobes
- wbs_sel_i  input  4  ignored; all accesses are full-word
- wbs_adr_i  input  32  address; selected when adr[31:24]==8'h31
- wbs_dat_i  input  32  write data
- wbs_ack_o  output  1  registered acknowledge
- wbs_dat_o  output  32  read data, valid with ack

## Operation
- Registers are decoded on adr[7:0]; unmapped offsets ack and read 0:
  - 0x00 CTRL (RW): bit0 EN, reset 0. bit1 CLR is write-1 self-clearing and reads 0.
  - 0x04 FRAME_LEN (RW) [15:0]: reset 0. Value 0 means out_last is never asserted.
  - 0x08 STATUS (RO): [AW:0] occupancy, where AW=clog2(DEPTH). bit16 OVF sticky, bit17 empty, bit18 full.
  - 0x0C DROP_CNT (RO) [15:0]: saturates at 16'hFFFF.
- Wishbone FSM has states IDLE and ACK:
  - IDLE→ACK when cyc&stb&selected. The write takes effect on that edge, or read data is latched.
  - ACK drives ack_o=1 for exactly one cycle, then returns to IDLE.
  - A request still held during ACK is not re-acked until it passes through IDLE again.
- Push: in_valid & EN & (!full | pop).
  - A push into a full FIFO is legal only with a simultaneous pop.
  - in_valid with EN=0 is silently ignored: no OVF, no DROP_CNT change.
- Drop: in_valid & EN & full & !pop. This sets OVF and increments DROP_CNT (saturating).
- Pop: out_valid & out_ready.
- Frame counter word_cnt is 16 bits.
  - On each pop it increments. When the popped word had out_last=1 it wraps to 0 instead.
  - out_last = out_valid & (FRAME_LEN!=0) & (word_cnt >= FRAME_LEN-1).
  - A FRAME_LEN write mid-frame takes effect on the next cycle. Because the compare is ≥, a shortened frame ends at the next pop.
- CLR, and the cycle it is written, does all of the following on that edge:
  - empties the FIFO and resets the pointers;
  - zeroes word_cnt, OVF and DROP_CNT;
  - discards any simultaneous in_valid word without counting it;
  - leaves EN and FRAME_LEN unchanged.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, wbs_ack_o=0, wbs_dat_o=0. All counters, pointers, OVF and registers are 0.
- Push-to-output latency: a word pushed on edge N is visible with out_valid=1 after edge N (one cycle).
- Throughput: one push and one pop per cycle sustained. Occupancy is unchanged on simultaneous push and pop.
- Register access: ack is asserted the cycle after stb is sampled. wbs_dat_o reflects state at the sampling edge and returns to 0 after ack.
- Status effects are visible on STATUS reads from the next edge, e.g. a drop on edge N reads back from edge N+1.
- Reset mid-transfer discards the FIFO contents, aborts any pending ack, and restores all reset values immediately.

## Test plan
- Reset, then write CTRL=1 and FRAME_LEN=4, push 8 words 0x10..0x17 with out_ready=1:
  - out sequence is 0x10..0x17;
  - out_last is set on 0x13 and 0x17;
  - STATUS reads empty=1, occupancy 0.
- EN=1, out_ready=0, push 10 words:
  - FIFO holds the first 8;
  - STATUS shows full=1 and OVF=1;
  - DROP_CNT=2;
  - draining yields words 1–8 in order.
- Full FIFO, out_ready=1 and in_valid=1 for 4 cycles: no drops, occupancy stays 8, the pushed words follow in order.
- in_valid with EN=0: out_valid stays 0, DROP_CNT=0, OVF=0.
- Full with OVF=1 and DROP_CNT=5, with in_valid in the same cycle, write CTRL=3:
  - next cycle out_valid=0, STATUS OVF=0, occupancy 0, DROP_CNT=0;
  - CTRL reads back 1.
- Assert reset during ack and during a burst: outputs return to reset values asynchronously, and the first post-reset access acks normally.

Source files
------------

// File: rtl/acc_stream_rx.sv
// rtl/acc_stream_rx.sv - DMA receive FIFO with valid/ready output, framing and Wishbone control window
//
// Purpose:
//   Absorbs the DMA's valid-only word bursts in a first-word-fall-through
//   FIFO, presents them on a valid/ready stream with end-of-frame marking,
//   and tracks overflow and dropped words for the CPU.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   in_valid, in_data       DMA word strobe and data (no backpressure)
//   out_valid, out_data     FIFO head word (data forced to 0 when empty)
//   out_last, out_ready     end-of-frame flag, consumer accept
//   wbs_*                   Wishbone slave: CTRL 0x00, FRAME_LEN 0x04,
//                           STATUS 0x08, DROP_CNT 0x0C (window adr[31:24]=0x31)

module acc_stream_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {WB_IDLE, WB_ACK} wb_state_t;

  wb_state_t             r_state;
  wb_state_t             w_state_nxt;
  logic                  w_accept;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  r_en;
  logic [15:0]           r_frame_len;
  logic [15:0]           r_word_cnt;
  logic                  r_ovf;
  logic [15:0]           r_drop_cnt;
  logic [31:0]           r_dat_o;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_req;
  logic                  w_wr_ctrl;
  logic                  w_wr_flen;
  logic                  w_clr;
  logic [31:0]           w_rd_data;
  logic                  w_unused_ok;

  assign w_unused_ok = ^{wbs_sel_i, wbs_adr_i[23:8], wbs_dat_i[31:16]};

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign out_valid = !w_empty;
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_last  = out_valid && (r_frame_len != 16'd0) &&
                     (r_word_cnt >= (r_frame_len - 16'd1));

  assign w_pop  = out_valid && out_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_push = in_valid && r_en && (!w_full || w_pop);
  assign w_drop = in_valid && r_en && w_full && !w_pop;

  assign w_req     = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:24] == 8'h31);
  assign w_wr_ctrl = w_accept && wbs_we_i && (wbs_adr_i[7:0] == 8'h00);
  assign w_wr_flen = w_accept && wbs_we_i && (wbs_adr_i[7:0] == 8'h04);
  assign w_clr     = w_wr_ctrl && wbs_dat_i[1];

  assign wbs_ack_o = (r_state == WB_ACK);
  assign wbs_dat_o = r_dat_o;

  always_comb begin
    w_rd_data = 32'd0;
    case (wbs_adr_i[7:0])
      8'h00:   w_rd_data = {31'd0, r_en};
      8'h04:   w_rd_data = {16'd0, r_frame_len};
      8'h08:   w_rd_data = {13'd0, w_full, w_empty, r_ovf,
                            {(16-AW-1){1'b0}}, r_count};
      8'h0C:   w_rd_data = {16'd0, r_drop_cnt};
      default: w_rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= WB_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ACK always falls back to IDLE, so a held request needs a fresh IDLE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      WB_IDLE: begin
        if (w_req) begin
          w_accept    = 1'b1;
          w_state_nxt = WB_ACK;
        end
      end
      default: w_state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push && !w_clr) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_en        <= 1'b0;
      r_frame_len <= 16'd0;
      r_word_cnt  <= 16'd0;
      r_ovf       <= 1'b0;
      r_drop_cnt  <= 16'd0;
      r_dat_o     <= 32'd0;
    end else begin
      if (w_accept && !wbs_we_i) r_dat_o <= w_rd_data;
      else                       r_dat_o <= 32'd0;

      if (w_wr_ctrl) r_en        <= wbs_dat_i[0];
      if (w_wr_flen) r_frame_len <= wbs_dat_i[15:0];

      if (w_clr) begin
        // Clear wins over any same-cycle push, pop or drop.
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_word_cnt <= 16'd0;
        r_ovf      <= 1'b0;
        r_drop_cnt <= 16'd0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        if (w_pop) r_word_cnt <= out_last ? 16'd0 : r_word_cnt + 16'd1;
        if (w_drop) begin
          r_ovf <= 1'b1;
          if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end
  end

endmodule
